// File: rtl/ascii_pkg.sv
// Shared ASCII digit constants and helpers for the BCD counter.
package ascii_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] ASCII_ZERO = 8'h30;
    localparam logic [BYTE_W-1:0] ASCII_NINE = 8'h39;

    // True when the byte is one of the characters "0".."9".
    function automatic logic is_ascii_digit(input logic [BYTE_W-1:0] ch);
        return (ch >= ASCII_ZERO) && (ch <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/ascii_digit_step.sv
// One ASCII decimal digit of the counter ripple: applies a +1/-1 when carry_in is set.
module ascii_digit_step
    import ascii_pkg::*;
(
    input  logic [BYTE_W-1:0] digit,
    input  logic              up,
    input  logic              carry_in,
    output logic [BYTE_W-1:0] next_digit,
    output logic              carry_out
);

    // Increment/decrement one digit; carry_out doubles as the borrow when counting down.
    always_comb begin
        next_digit = digit;
        carry_out  = 1'b0;
        if (carry_in) begin
            if (up) begin
                if (digit == ASCII_NINE) begin
                    next_digit = ASCII_ZERO;
                    carry_out  = 1'b1;
                end else begin
                    next_digit = digit + BYTE_W'(1);
                end
            end else begin
                if (digit == ASCII_ZERO) begin
                    next_digit = ASCII_NINE;
                    carry_out  = 1'b1;
                end else begin
                    next_digit = digit - BYTE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ascii_bcd_counter.sv
// Up/down counter held as DIGITS ASCII decimal characters, with wrap or saturate at the limits.
module ascii_bcd_counter
    import ascii_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b0
)(
    input  logic                     clock,
    input  logic                     reset,
    input  logic [BYTE_W*DIGITS-1:0] ascii_in,
    input  logic                     load,
    input  logic                     enable,
    input  logic                     up,
    output logic [BYTE_W*DIGITS-1:0] counter,
    output logic                     done,
    output logic                     wrapped,
    output logic                     saturated,
    output logic                     load_err
);

    localparam int unsigned W = BYTE_W * DIGITS;

    logic [DIGITS:0] carry;
    logic [W-1:0]    stepped;
    logic [W-1:0]    terminal;
    logic            load_ok;
    logic            limit_hit;

    logic [W-1:0]    counter_d;
    logic            done_d;
    logic            wrapped_d;
    logic            saturated_d;
    logic            load_err_d;

    // The LSD always receives the step; the carry out of the MSD marks a limit crossing.
    assign carry[0]  = 1'b1;
    assign limit_hit = carry[DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        ascii_digit_step u_step (
            .digit      (counter[BYTE_W*i +: BYTE_W]),
            .up         (up),
            .carry_in   (carry[i]),
            .next_digit (stepped[BYTE_W*i +: BYTE_W]),
            .carry_out  (carry[i+1])
        );
    end

    // Terminal value depends on the requested direction.
    assign terminal = up ? {DIGITS{ASCII_NINE}} : {DIGITS{ASCII_ZERO}};

    // A load is accepted only if every byte is an ASCII decimal digit.
    always_comb begin
        load_ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!is_ascii_digit(ascii_in[BYTE_W*i +: BYTE_W])) begin
                load_ok = 1'b0;
            end
        end
    end

    // Next-state selection: load beats step beats hold; pulses default low.
    always_comb begin
        counter_d   = counter;
        done_d      = done;
        wrapped_d   = 1'b0;
        saturated_d = 1'b0;
        load_err_d  = 1'b0;
        if (load) begin
            if (load_ok) begin
                counter_d = ascii_in;
                done_d    = (ascii_in == terminal);
            end else begin
                load_err_d = 1'b1;
            end
        end else if (enable) begin
            if (limit_hit && !WRAP) begin
                saturated_d = 1'b1;
            end else begin
                counter_d = stepped;
                wrapped_d = limit_hit;
            end
            done_d = (counter_d == terminal);
        end
    end

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            counter   <= {DIGITS{ASCII_ZERO}};
            done      <= 1'b0;
            wrapped   <= 1'b0;
            saturated <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            counter   <= counter_d;
            done      <= done_d;
            wrapped   <= wrapped_d;
            saturated <= saturated_d;
            load_err  <= load_err_d;
        end
    end

endmodule

// File: tb/tb_ascii_bcd_counter.sv
// Scoreboard bench: three counter instances (4-digit saturate, 4-digit wrap, 2-digit saturate)
// driven with shared stimulus and checked against an integer reference model.
module tb_ascii_bcd_counter;

    typedef logic [35:0] obs_t;

    typedef struct packed {
        logic        r;
        logic        ld;
        logic        en;
        logic        u;
        logic [31:0] data;
    } stim_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic        enable = 1'b0;
    logic        up = 1'b0;
    logic [31:0] ascii_in = 32'h3030_3030;

    logic [31:0] cnt_s, cnt_w;
    logic [15:0] cnt_2;
    logic        done_s, wrp_s, sat_s, lerr_s;
    logic        done_w, wrp_w, sat_w, lerr_w;
    logic        done_2, wrp_2, sat_2, lerr_2;

    obs_t obs[3];
    obs_t q[3][$];
    int   mval[3];
    logic mdone[3];
    int   passed = 0;
    int   total  = 0;

    always #5 clock = ~clock;

    ascii_bcd_counter #(.DIGITS(4), .WRAP(1'b0)) u_sat (
        .clock(clock), .reset(reset), .ascii_in(ascii_in), .load(load), .enable(enable), .up(up),
        .counter(cnt_s), .done(done_s), .wrapped(wrp_s), .saturated(sat_s), .load_err(lerr_s)
    );

    ascii_bcd_counter #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
        .clock(clock), .reset(reset), .ascii_in(ascii_in), .load(load), .enable(enable), .up(up),
        .counter(cnt_w), .done(done_w), .wrapped(wrp_w), .saturated(sat_w), .load_err(lerr_w)
    );

    ascii_bcd_counter #(.DIGITS(2), .WRAP(1'b0)) u_d2 (
        .clock(clock), .reset(reset), .ascii_in(ascii_in[15:0]), .load(load), .enable(enable), .up(up),
        .counter(cnt_2), .done(done_2), .wrapped(wrp_2), .saturated(sat_2), .load_err(lerr_2)
    );

    assign obs[0] = {cnt_s, done_s, wrp_s, sat_s, lerr_s};
    assign obs[1] = {cnt_w, done_w, wrp_w, sat_w, lerr_w};
    assign obs[2] = {16'h0000, cnt_2, done_2, wrp_2, sat_2, lerr_2};

    function automatic int nd(input int d);
        return (d == 2) ? 2 : 4;
    endfunction

    function automatic logic wr(input int d);
        return d == 1;
    endfunction

    function automatic int pow10(input int k);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] to_ascii(input int v, input int n);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = 8'(48 + ((v / pow10(k)) % 10));
        return r;
    endfunction

    // Drive one cycle of stimulus, push model predictions for every instance, then step the clock.
    task automatic apply(input stim_t s);
        int          mx, term, v;
        logic        ok, w, sat, le;
        logic [7:0]  b;
        reset    = s.r;
        load     = s.ld;
        enable   = s.en;
        up       = s.u;
        ascii_in = s.data;
        for (int d = 0; d < 3; d++) begin
            mx   = pow10(nd(d)) - 1;
            term = s.u ? mx : 0;
            ok   = 1'b1;
            v    = 0;
            w    = 1'b0;
            sat  = 1'b0;
            le   = 1'b0;
            for (int k = 0; k < nd(d); k++) begin
                b = s.data[8*k +: 8];
                if (b < 8'h30 || b > 8'h39) ok = 1'b0;
                else v = v + (int'(b) - 48) * pow10(k);
            end
            if (!s.r) begin
                mval[d]  = 0;
                mdone[d] = 1'b0;
            end else if (s.ld) begin
                if (ok) begin
                    mval[d]  = v;
                    mdone[d] = (v == term);
                end else begin
                    le = 1'b1;
                end
            end else if (s.en) begin
                if (s.u) begin
                    if (mval[d] == mx) begin
                        if (wr(d)) begin mval[d] = 0; w = 1'b1; end
                        else sat = 1'b1;
                    end else mval[d] = mval[d] + 1;
                end else begin
                    if (mval[d] == 0) begin
                        if (wr(d)) begin mval[d] = mx; w = 1'b1; end
                        else sat = 1'b1;
                    end else mval[d] = mval[d] - 1;
                end
                mdone[d] = (mval[d] == term);
            end
            q[d].push_back({to_ascii(mval[d], nd(d)), mdone[d], w, sat, le});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        stim_t rows[3];
        obs_t  e;
        rows = '{'{1'b0, 1'b1, 1'b0, 1'b0, "1234"},
                 '{1'b0, 1'b1, 1'b1, 1'b1, "1234"},
                 '{1'b1, 1'b0, 1'b0, 1'b0, "1234"}};
        for (int i = 0; i < 3; i++) begin
            apply(rows[i]);
            for (int d = 0; d < 3; d++) begin
                e = q[d].pop_front();
                total++;
                if (obs[d] !== e) $display("FAIL reset dut%0d cyc%0d: got %h want %h", d, i, obs[d], e);
                else passed++;
            end
        end
        total++;
        if (cnt_s !== "0000" || done_s !== 1'b0) $display("FAIL reset_const: got %h want %h", cnt_s, "0000");
        else passed++;
    endtask

    task automatic test_down_steps();
        stim_t rows[4];
        obs_t  e;
        rows = '{'{1'b1, 1'b1, 1'b0, 1'b0, "0021"},
                 '{1'b1, 1'b0, 1'b1, 1'b0, "0000"},
                 '{1'b1, 1'b0, 1'b1, 1'b0, "0000"},
                 '{1'b1, 1'b0, 1'b1, 1'b0, "0000"}};
        for (int i = 0; i < 4; i++) begin
            apply(rows[i]);
            for (int d = 0; d < 3; d++) begin
                e = q[d].pop_front();
                total++;
                if (obs[d] !== e) $display("FAIL down_steps dut%0d cyc%0d: got %h want %h", d, i, obs[d], e);
                else passed++;
            end
        end
        total++;
        if (cnt_s !== "0018") $display("FAIL down_const: got %h want %h", cnt_s, "0018");
        else passed++;
    endtask

    task automatic test_saturate();
        stim_t rows[4];
        obs_t  e;
        rows = '{'{1'b1, 1'b1, 1'b0, 1'b0, "0001"},
                 '{1'b1, 1'b0, 1'b1, 1'b0, "0000"},
                 '{1'b1, 1'b0, 1'b1, 1'b0, "0000"},
                 '{1'b1, 1'b0, 1'b1, 1'b1, "0000"}};
        for (int i = 0; i < 4; i++) begin
            apply(rows[i]);
            for (int d = 0; d < 3; d++) begin
                e = q[d].pop_front();
                total++;
                if (obs[d] !== e) $display("FAIL saturate dut%0d cyc%0d: got %h want %h", d, i, obs[d], e);
                else passed++;
            end
        end
    endtask

    task automatic test_wrap();
        stim_t rows[3];
        obs_t  e;
        rows = '{'{1'b1, 1'b1, 1'b0, 1'b0, "0000"},
                 '{1'b1, 1'b0, 1'b1, 1'b0, "0000"},
                 '{1'b1, 1'b0, 1'b1, 1'b1, "0000"}};
        for (int i = 0; i < 3; i++) begin
            apply(rows[i]);
            for (int d = 0; d < 3; d++) begin
                e = q[d].pop_front();
                total++;
                if (obs[d] !== e) $display("FAIL wrap dut%0d cyc%0d: got %h want %h", d, i, obs[d], e);
                else passed++;
            end
            if (i == 1) begin
                total++;
                if (cnt_w !== "9999" || wrp_w !== 1'b1) $display("FAIL wrap_const: got %h/%b want 9999/1", cnt_w, wrp_w);
                else passed++;
            end
        end
    endtask

    task automatic test_load_err();
        stim_t rows[3];
        obs_t  e;
        rows = '{'{1'b1, 1'b1, 1'b0, 1'b0, "0042"},
                 '{1'b1, 1'b1, 1'b1, 1'b0, "0A12"},
                 '{1'b1, 1'b0, 1'b0, 1'b0, "0A12"}};
        for (int i = 0; i < 3; i++) begin
            apply(rows[i]);
            for (int d = 0; d < 3; d++) begin
                e = q[d].pop_front();
                total++;
                if (obs[d] !== e) $display("FAIL load_err dut%0d cyc%0d: got %h want %h", d, i, obs[d], e);
                else passed++;
            end
        end
    endtask

    task automatic test_two_digit();
        stim_t rows[4];
        obs_t  e;
        rows = '{'{1'b1, 1'b1, 1'b0, 1'b1, "0099"},
                 '{1'b1, 1'b0, 1'b1, 1'b1, "0000"},
                 '{1'b1, 1'b1, 1'b1, 1'b1, "0050"},
                 '{1'b1, 1'b0, 1'b1, 1'b1, "0000"}};
        for (int i = 0; i < 4; i++) begin
            apply(rows[i]);
            for (int d = 0; d < 3; d++) begin
                e = q[d].pop_front();
                total++;
                if (obs[d] !== e) $display("FAIL two_digit dut%0d cyc%0d: got %h want %h", d, i, obs[d], e);
                else passed++;
            end
        end
    endtask

    task automatic test_dir_change();
        stim_t rows[4];
        obs_t  e;
        rows = '{'{1'b1, 1'b1, 1'b0, 1'b0, "0000"},
                 '{1'b1, 1'b0, 1'b0, 1'b1, "0000"},
                 '{1'b1, 1'b0, 1'b0, 1'b0, "0000"},
                 '{1'b1, 1'b0, 1'b1, 1'b1, "0000"}};
        for (int i = 0; i < 4; i++) begin
            apply(rows[i]);
            for (int d = 0; d < 3; d++) begin
                e = q[d].pop_front();
                total++;
                if (obs[d] !== e) $display("FAIL dir_change dut%0d cyc%0d: got %h want %h", d, i, obs[d], e);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        obs_t  e;
        for (int i = 0; i < 400; i++) begin
            s.r  = ($urandom_range(0, 59) != 0);
            s.ld = ($urandom_range(0, 7) == 0);
            s.en = ($urandom_range(0, 3) != 0);
            s.u  = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 15) == 0) s.data[8*k +: 8] = 8'($urandom_range(0, 255));
                else s.data[8*k +: 8] = 8'(48 + $urandom_range(0, 9));
            end
            if ($urandom_range(0, 4) == 0) s.data = (s.u) ? "9998" : "0002";
            apply(s);
            for (int d = 0; d < 3; d++) begin
                e = q[d].pop_front();
                total++;
                if (obs[d] !== e) $display("FAIL back_to_back dut%0d cyc%0d: got %h want %h", d, i, obs[d], e);
                else passed++;
            end
        end
    endtask

    initial begin
        mval  = '{0, 0, 0};
        mdone = '{1'b0, 1'b0, 1'b0};
        @(posedge clock);
        #1;
        test_reset();
        test_down_steps();
        test_saturate();
        test_wrap();
        test_load_err();
        test_two_digit();
        test_dir_change();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
